clk_lock_sequencer: RTL

- Sits directly downstream of the clock wizard.
- Consumes the wizard's `locked` status, synchronises it into the clk_1 domain and qualifies it for stability.
- Sequences a clean synchronous reset (sys_rst) for all clk_1 logic.
- Provides a lock-loss counter and a heartbeat toggle so a board LED or ILA shows the clk_1 domain is alive.

---
 rtl/clk_lock_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/clk_lock_sequencer.sv
// clk_lock_sequencer: synchronises and qualifies the wizard lock, sequences sys_rst,
// counts lock losses in RUN and drives a heartbeat for the clk_1 domain.
module clk_lock_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 64,
    parameter int HB_DIV        = 25000000
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       locked,
    input  logic       clr_loss,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic       heartbeat,
    output logic       beat_pulse
);
    localparam int CMAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int HW   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hb_q, hb_d;
    logic [7:0]    loss_q, loss_d;
    logic          ff1_q, locked_s_q;
    logic          heartbeat_q, heartbeat_d;
    logic          beat_q, beat_d;
    logic          stay_run, hb_wrap, loss_ev;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            WAIT_LOCK: if (locked_s_q) state_d = STABLE;
            STABLE: begin
                if (!locked_s_q) state_d = WAIT_LOCK;
                else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = HOLD;
                else cnt_d = cnt_q + CW'(1);
            end
            HOLD: begin
                if (!locked_s_q) state_d = WAIT_LOCK;
                else if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = RUN;
                else cnt_d = cnt_q + CW'(1);
            end
            RUN:       if (!locked_s_q) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
        // Heartbeat only advances on edges that both start and end in RUN, so each entry restarts it low
        stay_run    = (state_q == RUN) && locked_s_q;
        hb_wrap     = (hb_q == HW'(HB_DIV - 1));
        hb_d        = (stay_run && !hb_wrap) ? hb_q + HW'(1) : '0;
        heartbeat_d = stay_run ? (heartbeat_q ^ hb_wrap) : 1'b0;
        beat_d      = stay_run && hb_wrap;
        loss_ev     = (state_q == RUN) && !locked_s_q;
        loss_d      = clr_loss ? {7'd0, loss_ev} :
                      (loss_ev && loss_q != 8'hff) ? loss_q + 8'd1 : loss_q;
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            ff1_q       <= 1'b0;
            locked_s_q  <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            hb_q        <= '0;
            heartbeat_q <= 1'b0;
            beat_q      <= 1'b0;
            loss_q      <= '0;
        end else begin
            ff1_q       <= locked;
            locked_s_q  <= ff1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hb_q        <= hb_d;
            heartbeat_q <= heartbeat_d;
            beat_q      <= beat_d;
            loss_q      <= loss_d;
        end
    end

    assign sys_rst    = (state_q != RUN);
    assign ready      = (state_q == RUN);
    assign loss_count = loss_q;
    assign heartbeat  = heartbeat_q;
    assign beat_pulse = beat_q;
endmodule
